puertas_pipe: RTL

//  Parametrised, pipelined successor of the single-bit gate block: applies one of

---
 rtl/puertas_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/puertas_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Produces op(A,B) plus zero/parity/popcount flags and a completed-transfer counter.
module puertas_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [2:0]                   i_op,
    input  logic [WIDTH-1:0]             i_a,
    input  logic [WIDTH-1:0]             i_b,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_result,
    output logic [2:0]                   o_op,
    output logic                         o_zero,
    output logic                         o_parity,
    output logic [$clog2(WIDTH+1)-1:0]   o_ones,
    output logic [CNT_W-1:0]             o_tx_count
);

    localparam int ONES_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_NAND   = 3'd1,
        OP_OR     = 3'd2,
        OP_NOR    = 3'd3,
        OP_NOT_A  = 3'd4,
        OP_XOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    // Handshake / advance
    logic adv1;
    logic adv2;

    // Stage 1: captured operands
    logic             v1;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2: result and flags
    logic              v2;
    op_e               s2_op;
    logic [WIDTH-1:0]  s2_result;
    logic              s2_zero;
    logic              s2_parity;
    logic [ONES_W-1:0] s2_ones;

    // Combinational result of stage 1
    logic [WIDTH-1:0]  f_result;
    logic [ONES_W-1:0] f_ones;

    logic [CNT_W-1:0]  tx_count;

    // A stage advances when it is empty or the stage after it is moving; the
    // ready path is therefore combinational from i_ready all the way to o_ready.
    assign adv2    = !v2 || i_ready;
    assign adv1    = !v1 || adv2;
    assign o_ready = adv1;

    // NOTE: only the valid bit needs a reset; the payload is qualified by v1, so
    // leaving it unreset keeps reset fan-out off the wide data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= i_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge i_clk) begin
        if (adv1) begin
            s1_op <= op_e'(i_op);
            s1_a  <= i_a;
            s1_b  <= i_b;
        end
    end

    // NOTE: combinational outputs get a default before the case so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        f_result = '0;
        unique case (s1_op)
            OP_AND:    f_result = s1_a & s1_b;
            OP_NAND:   f_result = ~(s1_a & s1_b);
            OP_OR:     f_result = s1_a | s1_b;
            OP_NOR:    f_result = ~(s1_a | s1_b);
            OP_NOT_A:  f_result = ~s1_a;
            OP_XOR:    f_result = s1_a ^ s1_b;
            OP_XNOR:   f_result = ~(s1_a ^ s1_b);
            OP_PASS_B: f_result = s1_b;
        endcase
    end

    always_comb begin
        f_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f_ones = f_ones + ONES_W'(f_result[i]);
        end
    end

    // Stage 2 holds everything while stalled, so the outputs stay stable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v2        <= 1'b0;
            s2_op     <= OP_AND;
            s2_result <= '0;
            s2_zero   <= 1'b1;
            s2_parity <= 1'b0;
            s2_ones   <= '0;
        end else if (adv2) begin
            v2        <= v1;
            s2_op     <= s1_op;
            s2_result <= f_result;
            s2_zero   <= ~|f_result;
            s2_parity <= ^f_result;
            s2_ones   <= f_ones;
        end
    end

    // Counts sink-side transfers; wraps naturally at 2^CNT_W.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_count <= '0;
        end else if (v2 && i_ready) begin
            tx_count <= tx_count + 1'b1;
        end
    end

    assign o_valid    = v2;
    assign o_result   = s2_result;
    assign o_op       = s2_op;
    assign o_zero     = s2_zero;
    assign o_parity   = s2_parity;
    assign o_ones     = s2_ones;
    assign o_tx_count = tx_count;

endmodule
